// File: rtl/ltssm_detect_ctrl.sv
// LTSSM Detect-phase sequencer: Quiet -> Active (Detect_req / Detect_status handshake) -> Done or retry.
// Optional retry limit (FAIL state, sticky detect_fail) is enabled by defining DETECT_RETRY_LIMIT_EN.
module ltssm_detect_ctrl #(
  parameter logic [23:0] QUIET_CYCLES  = 24'd3000000,
  parameter logic [15:0] ACTIVE_CYCLES = 16'd2500,
  parameter logic [3:0]  MAX_RETRIES   = 4'd8
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       start,
  input  logic       RxElecIdle,
  input  logic       Detect_status,
  output logic       ElecIdle_req,
  output logic       Detect_req,
  output logic       detect_done,
  output logic       detect_fail,
  output logic [2:0] det_state,
  output logic [3:0] retry_cnt
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    QUIET       = 3'd1,
    ACTIVE_REQ  = 3'd2,
    ACTIVE_WAIT = 3'd3,
    DONE        = 3'd4,
    FAIL        = 3'd5
  } state_t;

`ifdef DETECT_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [23:0] quiet_cnt_q, quiet_cnt_d;
  logic [15:0] active_cnt_q, active_cnt_d;
  logic [3:0]  retry_cnt_q, retry_cnt_d;
  logic        detect_fail_q, detect_fail_d;
  logic        elec_idle_q, elec_idle_d;
  logic        detect_req_q, detect_req_d;
  logic        detect_done_q, detect_done_d;
  logic [4:0]  retry_inc;
  logic        retry_last;

  assign retry_inc  = {1'b0, retry_cnt_q} + 5'd1;
  assign retry_last = (retry_inc == {1'b0, MAX_RETRIES});

  always_comb begin
    state_d       = state_q;
    quiet_cnt_d   = quiet_cnt_q;
    active_cnt_d  = active_cnt_q;
    retry_cnt_d   = retry_cnt_q;
    detect_fail_d = detect_fail_q;

    if (!start) begin
      // Abandon whatever is in flight; only the failure flag survives.
      state_d      = IDLE;
      quiet_cnt_d  = '0;
      active_cnt_d = '0;
      retry_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d       = QUIET;
          quiet_cnt_d   = '0;
          retry_cnt_d   = '0;
          detect_fail_d = 1'b0;
        end
        QUIET: begin
          quiet_cnt_d = quiet_cnt_q + 24'd1;
          if ((quiet_cnt_q == QUIET_CYCLES - 24'd1) || !RxElecIdle) begin
            state_d = ACTIVE_REQ;
          end
        end
        ACTIVE_REQ: begin
          state_d      = ACTIVE_WAIT;
          active_cnt_d = '0;
        end
        ACTIVE_WAIT: begin
          active_cnt_d = active_cnt_q + 16'd1;
          if (Detect_status) begin
            state_d = DONE;
          end else if (active_cnt_q == ACTIVE_CYCLES - 16'd1) begin
            retry_cnt_d = (retry_cnt_q == 4'hF) ? 4'hF : retry_cnt_q + 4'd1;
            if (LIMIT_EN && retry_last) begin
              state_d       = FAIL;
              detect_fail_d = 1'b1;
            end else begin
              state_d     = QUIET;
              quiet_cnt_d = '0;
            end
          end
        end
        DONE, FAIL: state_d = state_q;
        default:    state_d = IDLE;
      endcase
    end

    // Detect_req tracks the state it belongs to; DONE outputs lag entry by one cycle.
    detect_req_d  = (state_d == ACTIVE_REQ);
    detect_done_d = start && (state_q == DONE);
    elec_idle_d   = !(start && (state_q == DONE));
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      quiet_cnt_q   <= '0;
      active_cnt_q  <= '0;
      retry_cnt_q   <= '0;
      detect_fail_q <= 1'b0;
      elec_idle_q   <= 1'b1;
      detect_req_q  <= 1'b0;
      detect_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      quiet_cnt_q   <= quiet_cnt_d;
      active_cnt_q  <= active_cnt_d;
      retry_cnt_q   <= retry_cnt_d;
      detect_fail_q <= detect_fail_d;
      elec_idle_q   <= elec_idle_d;
      detect_req_q  <= detect_req_d;
      detect_done_q <= detect_done_d;
    end
  end

  assign ElecIdle_req = elec_idle_q;
  assign Detect_req   = detect_req_q;
  assign detect_done  = detect_done_q;
  assign detect_fail  = detect_fail_q;
  assign det_state    = state_q;
  assign retry_cnt    = retry_cnt_q;

endmodule

// File: tb/tb_ltssm_detect_ctrl.sv
// Directed bench for ltssm_detect_ctrl with QUIET_CYCLES=20, ACTIVE_CYCLES=8, MAX_RETRIES=3.
module tb_ltssm_detect_ctrl;

  logic       pclk = 1'b0;
  logic       reset;
  logic       start;
  logic       RxElecIdle;
  logic       Detect_status;
  logic       ElecIdle_req;
  logic       Detect_req;
  logic       detect_done;
  logic       detect_fail;
  logic [2:0] det_state;
  logic [3:0] retry_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  ltssm_detect_ctrl #(
    .QUIET_CYCLES (24'd20),
    .ACTIVE_CYCLES(16'd8),
    .MAX_RETRIES  (4'd3)
  ) dut (
    .pclk         (pclk),
    .reset        (reset),
    .start        (start),
    .RxElecIdle   (RxElecIdle),
    .Detect_status(Detect_status),
    .ElecIdle_req (ElecIdle_req),
    .Detect_req   (Detect_req),
    .detect_done  (detect_done),
    .detect_fail  (detect_fail),
    .det_state    (det_state),
    .retry_cnt    (retry_cnt)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Ticks until Detect_req is seen; returns the tick count, or the budget on timeout.
  task automatic wait_req(input int budget, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (Detect_req !== 1'b1 && cnt < budget);
  endtask

  task automatic restart();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; RxElecIdle = 1'b1; Detect_status = 1'b0;
    #2;
    chk("rst_state", det_state, 0);
    chk("rst_elecidle", ElecIdle_req, 1);
    chk("rst_req", Detect_req, 0);
    chk("rst_done", detect_done, 0);
    chk("rst_fail", detect_fail, 0);
    chk("rst_retry", retry_cnt, 0);

    // Normal detection: 20 quiet cycles, one request, status 3 edges later.
    tick();
    reset = 1'b0; start = 1'b1;
    tick();
    chk("t1_quiet", det_state, 1);
    wait_req(40, n);
    chk("t1_quiet_len", n, 20);
    chk("t1_req_state", det_state, 2);
    chk("t1_req_elecidle", ElecIdle_req, 1);
    tick();
    chk("t1_req_pulse", Detect_req, 0);
    chk("t1_wait", det_state, 3);
    tick();
    Detect_status = 1'b1;
    tick();
    Detect_status = 1'b0;
    chk("t1_done_state", det_state, 4);
    chk("t1_done_lag", detect_done, 0);
    chk("t1_elecidle_lag", ElecIdle_req, 1);
    tick();
    chk("t1_done", detect_done, 1);
    chk("t1_elecidle_off", ElecIdle_req, 0);
    chk("t1_retry", retry_cnt, 0);
    tick();
    chk("t1_done_hold", det_state, 4);

    // Leaving DONE via start=0, then early exit from QUIET on receiver activity.
    start = 1'b0;
    tick();
    chk("t2_idle", det_state, 0);
    chk("t2_done_clr", detect_done, 0);
    chk("t2_elecidle", ElecIdle_req, 1);
    start = 1'b1;
    tick();
    repeat (4) tick();
    chk("t2_no_req_c5", Detect_req, 0);
    RxElecIdle = 1'b0;
    tick();
    RxElecIdle = 1'b1;
    chk("t2_req_c6", Detect_req, 1);
    chk("t2_req_state", det_state, 2);

    // Status pulse during QUIET is ignored; status on the timeout cycle wins.
    restart();
    repeat (3) tick();
    Detect_status = 1'b1;
    tick();
    Detect_status = 1'b0;
    chk("t3_quiet_ignore", det_state, 1);
    wait_req(40, n);
    chk("t3_quiet_rest", n, 16);
    repeat (8) tick();
    chk("t3_last_wait", det_state, 3);
    Detect_status = 1'b1;
    tick();
    Detect_status = 1'b0;
    chk("t3_coincide_done", det_state, 4);
    chk("t3_coincide_retry", retry_cnt, 0);

    // Timeouts without any status.
    restart();
    wait_req(40, n);
    chk("t4_first_req", n, 20);
    repeat (8) tick();
    chk("t4_wait_end", det_state, 3);
    tick();
    chk("t4_back_quiet", det_state, 1);
    chk("t4_retry1", retry_cnt, 1);
    wait_req(40, n);
    chk("t4_req2", n, 20);
`ifdef DETECT_RETRY_LIMIT_EN
    wait_req(40, n);
    chk("t4_req3", n, 29);
    chk("t4_retry2", retry_cnt, 2);
    repeat (9) tick();
    chk("t4_fail_state", det_state, 5);
    chk("t4_fail_flag", detect_fail, 1);
    chk("t4_fail_retry", retry_cnt, 3);
    n = 0;
    repeat (40) begin
      tick();
      if (Detect_req) n++;
    end
    chk("t4_fail_no_req", n, 0);
    chk("t4_fail_elecidle", ElecIdle_req, 1);
    start = 1'b0;
    tick();
    chk("t4_fail_sticky", detect_fail, 1);
    chk("t4_fail_idle", det_state, 0);
    start = 1'b1;
    tick();
    chk("t4_fail_clr", detect_fail, 0);
    chk("t4_restart_quiet", det_state, 1);
`else
    for (int i = 2; i <= 17; i++) begin
      wait_req(40, n);
      chk($sformatf("t4_period_%0d", i), n, 29);
      chk($sformatf("t4_retry_%0d", i), retry_cnt, (i > 15) ? 15 : i);
    end
    chk("t4_never_done", detect_done, 0);
    chk("t4_no_fail", detect_fail, 0);
`endif

    // Asynchronous reset in the middle of ACTIVE_WAIT after one timeout.
    restart();
    wait_req(40, n);
    wait_req(40, n);
    chk("t5_second_req", n, 29);
    tick();
    tick();
    chk("t5_pre_state", det_state, 3);
    chk("t5_pre_retry", retry_cnt, 1);
    #3 reset = 1'b1;
    #1;
    chk("t5_async_state", det_state, 0);
    chk("t5_async_retry", retry_cnt, 0);
    chk("t5_async_elecidle", ElecIdle_req, 1);
    chk("t5_async_req", Detect_req, 0);
    #1 reset = 1'b0;
    tick();
    chk("t5_requiet", det_state, 1);
    wait_req(40, n);
    chk("t5_full_quiet", n, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ltssm_detect_ctrl.md
Name: ltssm_detect_ctrl

Overview:
- Detect-phase sequencer of the LTSSM. It sits directly upstream of the PIPE control stage.
- Drives that stage's ElecIdle_req / Detect_req inputs and consumes its Detect_status result.
- Walks Detect.Quiet -> Detect.Active. On receiver detection it hands off to Polling via detect_done; otherwise it loops back to Quiet.

Parameters:
- QUIET_CYCLES, 24'd3000000, Detect.Quiet timeout in pclk cycles (12 ms at 250 MHz); legal range 2..2^24-1.
- ACTIVE_CYCLES, 16'd2500, max pclk cycles to wait for Detect_status after Detect_req (10 us); legal range 2..2^16-1.
- MAX_RETRIES, 4'd8, failed Active attempts before giving up (used only with DETECT_RETRY_LIMIT_EN).

Ports:
- pclk  in  1  PIPE clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  level; high enables the sequencer, low forces return to IDLE
- RxElecIdle  in  1  receiver electrical-idle indication from the PHY (1 = idle)
- Detect_status  in  1  one-cycle receiver-detected pulse from the PIPE control stage
- ElecIdle_req  out  1  request transmitter electrical idle
- Detect_req  out  1  one-cycle pulse requesting receiver detection
- detect_done  out  1  level; receiver found, proceed to Polling
- detect_fail  out  1  sticky; retry limit exhausted (0 when feature compiled out)
- det_state  out  3  encoded current state, for debug/LTSSM observation
- retry_cnt  out  4  failed Active attempts since start

Behaviour:
- Reset (asynchronous, reset=1) sets:
  - state=IDLE, ElecIdle_req=1, Detect_req=0, detect_done=0, detect_fail=0, retry_cnt=0, all timers 0.
- States and encodings: IDLE=0, QUIET=1, ACTIVE_REQ=2, ACTIVE_WAIT=3, DONE=4, FAIL=5.
- IDLE:
  - ElecIdle_req=1.
  - start=1 moves to QUIET next cycle; the quiet timer and retry_cnt clear.
- QUIET:
  - ElecIdle_req=1; quiet timer increments each cycle.
  - Exits to ACTIVE_REQ when the timer reaches QUIET_CYCLES-1, or when RxElecIdle=0 (receiver activity), whichever comes first.
  - If both occur in the same cycle: single transition to ACTIVE_REQ.
- ACTIVE_REQ:
  - Detect_req=1 for exactly this one cycle; ElecIdle_req stays 1 (detection is performed in electrical idle).
  - Always goes to ACTIVE_WAIT next cycle; the active timer clears.
- ACTIVE_WAIT:
  - Detect_req=0; the active timer increments.
  - Detect_status=1 moves to DONE.
  - Timer reaching ACTIVE_CYCLES-1 without Detect_status: retry_cnt increments (saturates at 15) and the FSM goes to QUIET with the quiet timer cleared.
  - Detect_status in the same cycle as the timeout: detection wins, go to DONE.
- DONE:
  - detect_done=1 and ElecIdle_req=0, both registered (asserted the cycle after entry).
  - Holds while start=1.
- Detect_status outside ACTIVE_WAIT is ignored.
- start=0 in any state returns to IDLE next cycle:
  - outputs take their reset values except detect_fail, which holds;
  - any pending detect attempt is abandoned.
- Output timing: all outputs are registered; no combinational path from input to output.
- Re-asserting start after DONE or FAIL restarts from QUIET with retry_cnt=0.

Optional Feature:
- Macro: DETECT_RETRY_LIMIT_EN.
- Defined: on a timeout in ACTIVE_WAIT, if retry_cnt+1 == MAX_RETRIES, the FSM goes to FAIL instead of QUIET.
  - In FAIL: detect_fail=1 (sticky until reset or a new start rising edge), ElecIdle_req=1, Detect_req never asserts.
  - FAIL holds until start=0.
- Not defined: FAIL state unreachable, detect_fail tied 0, retries unbounded.

Test Plan (sim with QUIET_CYCLES=20, ACTIVE_CYCLES=8, MAX_RETRIES=3):
- Reset release, start=1, RxElecIdle=1, Detect_status pulsed 3 cycles after Detect_req:
  - QUIET lasts 20 cycles, then one Detect_req pulse, DONE;
  - detect_done=1 and ElecIdle_req=0 one cycle later, retry_cnt=0.
- RxElecIdle drops 5 cycles into QUIET:
  - Detect_req asserts at cycle 6, not cycle 20.
- Detect_status never asserted, feature off:
  - Detect_req repeats every 20+1+8 = 29 cycles;
  - retry_cnt counts 1, 2, 3 ... and saturates at 15; detect_done stays 0.
- Feature on, no Detect_status:
  - after the 3rd timeout det_state=5, detect_fail=1, no further Detect_req;
  - start toggled 0 then 1 clears detect_fail and restarts QUIET.
- Detect_status coincident with ACTIVE_WAIT timeout cycle -> DONE, retry_cnt unchanged. Detect_status pulsed during QUIET -> ignored.
- reset asserted mid-ACTIVE_WAIT (asynchronous, between edges):
  - outputs immediately reach reset values (ElecIdle_req=1, others 0);
  - after release with start=1, a full 20-cycle QUIET repeats.
